// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register and single-outstanding instruction fetch handshake (optional PC_MISALIGN_TRAP_EN)
module pc_fetch_stage #(
    parameter int            n        = 32,
    parameter logic [n-1:0]  RESET_PC = '0
) (
    input  logic          clockInput,
    input  logic          resetNInput,
    input  logic [n-1:0]  nextPcInput,
    input  logic          redirectInput,
    output logic          imemReqOutput,
    output logic [n-1:0]  imemAddrOutput,
    input  logic          imemAckInput,
    input  logic [31:0]   imemDataInput,
    output logic          instrValidOutput,
    input  logic          instrReadyInput,
    output logic [31:0]   instrOutput,
    output logic [n-1:0]  pcOutput,
`ifdef PC_MISALIGN_TRAP_EN
    output logic          misalignOutput,
`endif
    output logic [n-1:0]  pcPlus4Output
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [n-1:0]   pcout_q, pcout_d;
    logic           pend_q, pend_d;
    logic [n-1:0]   pend_pc_q, pend_pc_d;
    logic           load_en;
    logic [n-1:0]   load_val;
    logic           valid;
`ifdef PC_MISALIGN_TRAP_EN
    logic           mis_q, mis_d;
`endif

    // A trapped misaligned PC parks in HOLD without presenting anything to decode
`ifdef PC_MISALIGN_TRAP_EN
    assign valid          = (state_q == HOLD) && !mis_q;
    assign misalignOutput = mis_q;
`else
    assign valid          = (state_q == HOLD);
`endif

    assign imemReqOutput    = (state_q == FETCH);
    assign imemAddrOutput   = pc_q;
    assign instrValidOutput = valid;
    assign instrOutput      = instr_q;
    assign pcOutput         = pcout_q;
    assign pcPlus4Output    = pc_q + {{(n-3){1'b0}}, 3'd4};

    // Next-state logic: request sequencing, deferred redirects and PC loads
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcout_d   = pcout_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        load_en   = 1'b0;
        load_val  = nextPcInput;
`ifdef PC_MISALIGN_TRAP_EN
        mis_d     = mis_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imemAckInput) begin
                    if (pend_q || redirectInput) begin
                        // Returned word belongs to a squashed path; a same-cycle redirect is the newest target
                        load_en  = 1'b1;
                        load_val = redirectInput ? nextPcInput : pend_pc_q;
                        pend_d   = 1'b0;
                    end else begin
                        instr_d = imemDataInput;
                        pcout_d = pc_q;
                        state_d = HOLD;
                    end
                end else if (redirectInput) begin
                    // Address must stay stable while outstanding, so only remember the latest target
                    pend_d    = 1'b1;
                    pend_pc_d = nextPcInput;
                end
            end
            HOLD: begin
                if (redirectInput || (valid && instrReadyInput)) begin
                    load_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
`ifdef PC_MISALIGN_TRAP_EN
            pc_d = load_val;
            if (load_val[1:0] != 2'b00) begin
                state_d = HOLD;
                mis_d   = 1'b1;
            end else begin
                state_d = FETCH;
                mis_d   = 1'b0;
            end
`else
            pc_d    = {load_val[n-1:2], 2'b00};
            state_d = FETCH;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clockInput or negedge resetNInput) begin
        if (!resetNInput) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pcout_q   <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcout_q   <= pcout_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q     <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed bench for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_pc;
    logic        redirect = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] data;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        use_tgt = 1'b0;
    logic [31:0] tgt = '0;
`ifdef PC_MISALIGN_TRAP_EN
    logic        mis;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;

    assign next_pc = use_tgt ? tgt : pc_plus4;
    assign data    = {8'hC0, addr[23:0]};

    pc_fetch_stage #(.n(32), .RESET_PC(32'h0000_0000)) dut (
        .clockInput      (clk),
        .resetNInput     (rst_n),
        .nextPcInput     (next_pc),
        .redirectInput   (redirect),
        .imemReqOutput   (req),
        .imemAddrOutput  (addr),
        .imemAckInput    (ack),
        .imemDataInput   (data),
        .instrValidOutput(valid),
        .instrReadyInput (ready),
        .instrOutput     (instr),
        .pcOutput        (pc_out),
`ifdef PC_MISALIGN_TRAP_EN
        .misalignOutput  (mis),
`endif
        .pcPlus4Output   (pc_plus4)
    );

    always #5 clk = ~clk;

    // Memory: ack in the third cycle of each request, nothing survives reset
    always @(posedge clk) begin
        #3;
        if (!rst_n || !req) begin
            cnt = 0;
            ack = 1'b0;
        end else begin
            if (ack) cnt = 0;
            cnt = cnt + 1;
            ack = (cnt >= 3);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        return {8'hC0, a[23:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at +5 inside the ack cycle
    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        #4;
        for (int i = 0; i < 10; i++) begin
            if (ack) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #5;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ack_timeout: got no ack, expected ack within 10 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        n_checks++;
        if (req !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got req=%b valid=%b, expected 0 0", req, valid);
        end
        n_checks++;
        if (instr !== 32'h0 || pc_out !== 32'h0 || addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got instr=%h pc=%h addr=%h, expected all 0", instr, pc_out, addr);
        end
        n_checks++;
        if (pc_plus4 !== 32'h4) begin
            n_fail++; $display("FAIL reset_plus4: got %h expected 00000004", pc_plus4);
        end
        rst_n = 1'b1;
        n_checks++;
        if (req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_gap: got req=%b expected 0", req);
        end
        step();
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_first_req: got req=%b addr=%h, expected 1 00000000", req, addr);
        end
    endtask

    task automatic test_fetch_seq();
        bit ok;
        logic [31:0] a;
        ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a = 32'(k * 4);
            wait_ack(ok);
            n_checks++;
            if (addr !== a) begin
                n_fail++; $display("FAIL seq_addr: got %h expected %h", addr, a);
            end
            step();
            n_checks++;
            if (valid !== 1'b1 || instr !== exp_instr(a) || pc_out !== a || req !== 1'b0) begin
                n_fail++; $display("FAIL seq_hold: got valid=%b instr=%h pc=%h req=%b, expected 1 %h %h 0",
                                   valid, instr, pc_out, req, exp_instr(a), a);
            end
            step();
            n_checks++;
            if (req !== 1'b1 || addr !== a + 32'h4) begin
                n_fail++; $display("FAIL seq_next: got req=%b addr=%h, expected 1 %h", req, addr, a + 32'h4);
            end
        end
    endtask

    task automatic test_redirect_fetch();
        bit ok;
        ready = 1'b0;
        redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h80;
        step();
        tgt = 32'h100;
        step();
        redirect = 1'b0; use_tgt = 1'b0;
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h8) begin
            n_fail++; $display("FAIL redir_addr_stable: got req=%b addr=%h, expected 1 00000008", req, addr);
        end
        wait_ack(ok);
        step();
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_discard: got req=%b addr=%h valid=%b, expected 1 00000100 0", req, addr, valid);
        end
        wait_ack(ok);
        step();
        n_checks++;
        if (valid !== 1'b1 || instr !== exp_instr(32'h100) || pc_out !== 32'h100) begin
            n_fail++; $display("FAIL redir_target: got valid=%b instr=%h pc=%h, expected 1 %h 00000100",
                               valid, instr, pc_out, exp_instr(32'h100));
        end
    endtask

    task automatic test_stall();
        bit ok;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (valid !== 1'b1 || instr !== exp_instr(32'h100) || pc_out !== 32'h100 || req !== 1'b0) begin
                n_fail++; $display("FAIL stall_cycle%0d: got valid=%b instr=%h pc=%h req=%b, expected 1 %h 00000100 0",
                                   i, valid, instr, pc_out, req, exp_instr(32'h100));
            end
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h104 || valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got req=%b addr=%h valid=%b, expected 1 00000104 0", req, addr, valid);
        end
        wait_ack(ok);
        step();
    endtask

    task automatic test_redirect_hold();
        bit ok;
        ready = 1'b1; redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h200;
        step();
        redirect = 1'b0; use_tgt = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin
            n_fail++; $display("FAIL hold_redirect: got valid=%b req=%b addr=%h, expected 0 1 00000200", valid, req, addr);
        end
        wait_ack(ok);
        step();
        n_checks++;
        if (valid !== 1'b1 || pc_out !== 32'h200 || instr !== exp_instr(32'h200)) begin
            n_fail++; $display("FAIL hold_target: got valid=%b pc=%h instr=%h, expected 1 00000200 %h",
                               valid, pc_out, instr, exp_instr(32'h200));
        end
        step();
    endtask

    task automatic test_redirect_on_ack();
        bit ok;
        wait_ack(ok);
        redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h300;
        step();
        redirect = 1'b0; use_tgt = 1'b0; ready = 1'b0;
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h300 || valid !== 1'b0) begin
            n_fail++; $display("FAIL ack_redirect: got req=%b addr=%h valid=%b, expected 1 00000300 0", req, addr, valid);
        end
        wait_ack(ok);
        step();
        n_checks++;
        if (valid !== 1'b1 || pc_out !== 32'h300) begin
            n_fail++; $display("FAIL ack_redirect_hold: got valid=%b pc=%h, expected 1 00000300", valid, pc_out);
        end
    endtask

    task automatic test_align();
        redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h102;
        step();
        redirect = 1'b0; use_tgt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        n_checks++;
        if (req !== 1'b0 || valid !== 1'b0 || mis !== 1'b1) begin
            n_fail++; $display("FAIL mis_trap: got req=%b valid=%b mis=%b, expected 0 0 1", req, valid, mis);
        end
        ready = 1'b1;
        step();
        n_checks++;
        if (req !== 1'b0 || valid !== 1'b0 || mis !== 1'b1) begin
            n_fail++; $display("FAIL mis_sticky: got req=%b valid=%b mis=%b, expected 0 0 1", req, valid, mis);
        end
        ready = 1'b0;
        redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h200;
        step();
        redirect = 1'b0; use_tgt = 1'b0;
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h200 || mis !== 1'b0) begin
            n_fail++; $display("FAIL mis_clear: got req=%b addr=%h mis=%b, expected 1 00000200 0", req, addr, mis);
        end
`else
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b0) begin
            n_fail++; $display("FAIL align_force: got req=%b addr=%h valid=%b, expected 1 00000100 0", req, addr, valid);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_drop: got req=%b valid=%b, expected 0 0", req, valid);
        end
        n_checks++;
        if (pc_out !== 32'h0 || instr !== 32'h0 || addr !== 32'h0) begin
            n_fail++; $display("FAIL midreset_regs: got pc=%h instr=%h addr=%h, expected all 0", pc_out, instr, addr);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL midreset_restart: got req=%b addr=%h, expected 1 00000000", req, addr);
        end
        wait_ack(ok);
        step();
        n_checks++;
        if (valid !== 1'b1 || instr !== exp_instr(32'h0) || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL midreset_instr: got valid=%b instr=%h pc=%h, expected 1 %h 00000000",
                               valid, instr, pc_out, exp_instr(32'h0));
        end
    endtask

    task automatic test_wrap();
        bit ok;
        redirect = 1'b1; use_tgt = 1'b1; tgt = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0; use_tgt = 1'b0;
        n_checks++;
        if (addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL wrap_plus4: got addr=%h plus4=%h, expected fffffffc 00000000", addr, pc_plus4);
        end
        ready = 1'b1;
        wait_ack(ok);
        step();
        n_checks++;
        if (valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instr !== exp_instr(32'hFFFF_FFFC)) begin
            n_fail++; $display("FAIL wrap_hold: got valid=%b pc=%h instr=%h, expected 1 fffffffc %h",
                               valid, pc_out, instr, exp_instr(32'hFFFF_FFFC));
        end
        step();
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got req=%b addr=%h, expected 1 00000000", req, addr);
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_redirect_fetch();
        test_stall();
        test_redirect_hold();
        test_redirect_on_ack();
        test_align();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
